// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared FSM states, ALU encodings and width defaults for the datapath controller
package dp_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_ITER_WIDTH = 4;
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_DONE
    } state_t;
endpackage

// File: rtl/dp_controller.sv
// dp_controller: sequences operand loads, repeated ALU passes and completion for the register-file datapath
module dp_controller
    import dp_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  shf,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [ADDR_WIDTH-1:0] addr_d,
    input  logic [ITER_WIDTH-1:0] iter,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  IE,
    output logic                  WE,
    output logic                  REA,
    output logic                  REB,
    output logic                  shift_en,
    output logic                  OE,
    output logic [ADDR_WIDTH-1:0] WA,
    output logic [ADDR_WIDTH-1:0] RAA,
    output logic [ADDR_WIDTH-1:0] RAB,
    output logic [1:0]            alu_op,
    output logic                  busy,
    output logic                  done
);
    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic                  shf_q, shf_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d, cnt_q, cnt_d;

    // State, latched transaction fields and pass counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            shf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            iter_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            shf_q   <= shf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and control strobes; the first EXEC pass is the one where the counter still equals iter
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shf_d    = shf_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        iter_d   = iter_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        IE       = 1'b0;
        WE       = 1'b0;
        REA      = 1'b0;
        REB      = 1'b0;
        shift_en = 1'b0;
        OE       = 1'b0;
        WA       = '0;
        RAA      = '0;
        RAB      = '0;
        alu_op   = '0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    shf_d   = shf;
                    a_d     = addr_a;
                    b_d     = addr_b;
                    d_d     = addr_d;
                    iter_d  = iter;
                    cnt_d   = iter;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                in_ready = 1'b1;
                IE       = 1'b1;
                WE       = in_valid;
                WA       = state_q == S_LOAD_A ? a_q : b_q;
                if (in_valid) state_d = state_q == S_LOAD_A ? S_LOAD_B : S_EXEC;
            end
            S_EXEC: begin
                REA      = 1'b1;
                REB      = 1'b1;
                RAA      = cnt_q == iter_q ? a_q : d_q;
                RAB      = b_q;
                alu_op   = op_q;
                shift_en = shf_q;
                WE       = 1'b1;
                WA       = d_q;
                OE       = 1'b1;
                if (cnt_q == '0) state_d = S_DONE;
                else cnt_d = cnt_q - 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_dp_controller.sv
// tb_dp_controller: directed checks of load, stall, accumulate, ignored start, reset and saturation behaviour
module tb_dp_controller;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = '0;
    logic       shf = 1'b0;
    logic [2:0] addr_a = '0, addr_b = '0, addr_d = '0;
    logic [3:0] iter = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, IE, WE, REA, REB, shift_en, OE, busy, done;
    logic [2:0] WA, RAA, RAB;
    logic [1:0] alu_op;
    logic [5:0] strb;
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;

    dp_controller dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .shf(shf),
        .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .iter(iter),
        .in_valid(in_valid), .in_ready(in_ready), .IE(IE), .WE(WE),
        .REA(REA), .REB(REB), .shift_en(shift_en), .OE(OE), .WA(WA),
        .RAA(RAA), .RAB(RAB), .alu_op(alu_op), .busy(busy), .done(done)
    );

    assign strb = {IE, WE, REA, REB, shift_en, OE};

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (done === 1'b1) done_cnt++;

    task automatic set_txn(input logic [1:0] o, input logic s, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] d, input logic [3:0] it);
        start = 1'b1; op = o; shf = s; addr_a = a; addr_b = b; addr_d = d; iter = it;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++; if ({strb, in_ready, busy, done} !== 9'd0) begin n_err++; $display("FAIL reset_strobes got %b want 0", {strb, in_ready, busy, done}); end
        n_cmp++; if ({WA, RAA, RAB, alu_op} !== 11'd0) begin n_err++; $display("FAIL reset_addr got %h want 0", {WA, RAA, RAB, alu_op}); end
        RST_N = 1'b1;
        @(negedge CLK);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single;
        int base;
        base = done_cnt;
        set_txn(2'd1, 1'b0, 3'd1, 3'd2, 3'd3, 4'd0);
        in_valid = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n_cmp++; if ({in_ready, IE, WE, busy} !== 4'b1111) begin n_err++; $display("FAIL single_load_a_ctl got %b want 1111", {in_ready, IE, WE, busy}); end
        n_cmp++; if (WA !== 3'd1) begin n_err++; $display("FAIL single_load_a_wa got %0d want 1", WA); end
        @(negedge CLK);
        n_cmp++; if (WA !== 3'd2 || WE !== 1'b1) begin n_err++; $display("FAIL single_load_b got wa=%0d we=%b want wa=2 we=1", WA, WE); end
        @(negedge CLK);
        n_cmp++; if ({RAA, RAB, WA} !== {3'd1, 3'd2, 3'd3}) begin n_err++; $display("FAIL single_exec_addr got %0d/%0d/%0d want 1/2/3", RAA, RAB, WA); end
        n_cmp++; if (strb !== 6'b011101 || alu_op !== 2'd1 || in_ready !== 1'b0) begin n_err++; $display("FAIL single_exec_ctl got %b op=%0d rdy=%b want 011101 op=1 rdy=0", strb, alu_op, in_ready); end
        @(negedge CLK);
        n_cmp++; if (done !== 1'b1 || strb !== 6'd0 || busy !== 1'b1) begin n_err++; $display("FAIL single_done got done=%b strb=%b busy=%b want 1/0/1", done, strb, busy); end
        @(negedge CLK);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL single_idle got busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL single_done_count got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_stall;
        set_txn(2'd0, 1'b0, 3'd7, 3'd6, 3'd5, 4'd0);
        in_valid = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge CLK);
            n_cmp++; if ({in_ready, IE, WE} !== 3'b110 || WA !== 3'd7) begin n_err++; $display("FAIL stall_%0d got rdy/ie/we=%b wa=%0d want 110 wa=7", i, {in_ready, IE, WE}, WA); end
        end
        in_valid = 1'b1;
        #1;
        n_cmp++; if (WE !== 1'b1 || WA !== 3'd7) begin n_err++; $display("FAIL stall_we_follow got we=%b wa=%0d want 1 wa=7", WE, WA); end
        @(negedge CLK);
        n_cmp++; if (WA !== 3'd6 || IE !== 1'b1) begin n_err++; $display("FAIL stall_load_b got wa=%0d ie=%b want 6/1", WA, IE); end
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done got %b want 1", done); end
        @(negedge CLK);
    endtask

    task automatic test_accumulate;
        logic [2:0] exp_raa;
        set_txn(2'd2, 1'b1, 3'd4, 3'd5, 3'd6, 4'd3);
        in_valid = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            exp_raa = (i == 0) ? 3'd4 : 3'd6;
            n_cmp++; if (RAA !== exp_raa || RAB !== 3'd5 || WA !== 3'd6) begin n_err++; $display("FAIL accum_addr_%0d got raa=%0d rab=%0d wa=%0d want %0d/5/6", i, RAA, RAB, WA, exp_raa); end
            n_cmp++; if (strb !== 6'b011111 || alu_op !== 2'd2) begin n_err++; $display("FAIL accum_ctl_%0d got %b op=%0d want 011111 op=2", i, strb, alu_op); end
        end
        @(negedge CLK);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL accum_done got %b want 1", done); end
        @(negedge CLK);
    endtask

    task automatic test_ignored_start;
        int base;
        base = done_cnt;
        set_txn(2'd1, 1'b0, 3'd1, 3'd2, 3'd3, 4'd1);
        in_valid = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        set_txn(2'd3, 1'b1, 3'd7, 3'd6, 3'd5, 4'd9);
        @(negedge CLK);
        start = 1'b0;
        n_cmp++; if ({RAA, RAB, WA, alu_op, shift_en} !== {3'd1, 3'd2, 3'd3, 2'd1, 1'b0}) begin n_err++; $display("FAIL ignore_exec1 got %0d/%0d/%0d op=%0d sh=%b want 1/2/3 op=1 sh=0", RAA, RAB, WA, alu_op, shift_en); end
        @(negedge CLK);
        n_cmp++; if (RAA !== 3'd3 || WA !== 3'd3) begin n_err++; $display("FAIL ignore_exec2 got raa=%0d wa=%0d want 3/3", RAA, WA); end
        @(negedge CLK);
        set_txn(2'd3, 1'b1, 3'd7, 3'd6, 3'd5, 4'd9);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ignore_done got %b want 1", done); end
        @(negedge CLK);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_done_start got busy=%b want 0", busy); end
        @(negedge CLK);
        n_cmp++; if (busy !== 1'b0 || done_cnt - base !== 1) begin n_err++; $display("FAIL ignore_one_done got busy=%b dones=%0d want 0/1", busy, done_cnt - base); end
    endtask

    task automatic test_mid_reset;
        set_txn(2'd1, 1'b1, 3'd1, 3'd2, 3'd3, 4'd5);
        in_valid = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (RAA !== 3'd3 || OE !== 1'b1) begin n_err++; $display("FAIL mreset_exec2 got raa=%0d oe=%b want 3/1", RAA, OE); end
        RST_N = 1'b0;
        #1;
        n_cmp++; if ({strb, in_ready, busy, done, WA, RAA, RAB, alu_op} !== 20'd0) begin n_err++; $display("FAIL mreset_outputs got %h want 0", {strb, in_ready, busy, done, WA, RAA, RAB, alu_op}); end
        @(negedge CLK);
        set_txn(2'd0, 1'b0, 3'd2, 3'd3, 3'd4, 4'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n_cmp++; if (WA !== 3'd2 || busy !== 1'b1) begin n_err++; $display("FAIL mreset_first_start got wa=%0d busy=%b want 2/1", WA, busy); end
        repeat (2) @(negedge CLK);
        n_cmp++; if ({RAA, RAB, WA} !== {3'd2, 3'd3, 3'd4}) begin n_err++; $display("FAIL mreset_fresh_exec got %0d/%0d/%0d want 2/3/4", RAA, RAB, WA); end
        @(negedge CLK);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mreset_fresh_done got %b want 1", done); end
        @(negedge CLK);
    endtask

    task automatic test_saturation;
        int execs;
        bit seen;
        execs = 0;
        seen = 1'b0;
        set_txn(2'd0, 1'b0, 3'd0, 3'd1, 3'd2, 4'd15);
        in_valid = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (OE === 1'b1) execs++;
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL sat_timeout got no done want done within 40 cycles"); end
        n_cmp++; if (execs !== 16) begin n_err++; $display("FAIL sat_exec_cycles got %0d want 16", execs); end
        @(negedge CLK);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_idle got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_accumulate();
        test_ignored_start();
        test_mid_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
